// File: rtl/bat_amateur_pkg.sv
// Shared defaults and state encoding for the BatAmateur boot memory.
package bat_amateur_pkg;

  localparam int unsigned DefAddressWidth = 16;
  localparam int unsigned DefDataWidth    = 16;
  localparam int unsigned DefMemDepth     = 256;

  typedef enum logic [1:0] {
    StClear,
    StLoad,
    StRun
  } state_e;

endpackage

// File: rtl/bat_amateur_ram.sv
// Single-port synchronous RAM, one-cycle read latency, read-before-write on collisions.
module bat_amateur_ram
  import bat_amateur_pkg::*;
#(
  parameter int unsigned DataWidth = DefDataWidth,
  parameter int unsigned Depth     = DefMemDepth,
  parameter int unsigned IdxWidth  = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [IdxWidth-1:0]  addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/bat_amateur_boot_mem.sv
// Program-load front end: clears RAM, accepts loader writes while halted, then serves the core.
module bat_amateur_boot_mem
  import bat_amateur_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DefAddressWidth,
  parameter int unsigned DATA_WIDTH    = DefDataWidth,
  parameter int unsigned MEM_DEPTH     = DefMemDepth
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     HALT,
  input  logic                     LOAD_VALID,
  input  logic [ADDRESS_WIDTH-1:0] LOAD_ADDR,
  input  logic [DATA_WIDTH-1:0]    LOAD_DATA,
  output logic                     LOAD_READY,
  input  logic                     CPU_RD,
  input  logic                     CPU_WR,
  input  logic [ADDRESS_WIDTH-1:0] CPU_ADDR,
  input  logic [DATA_WIDTH-1:0]    CPU_WDATA,
  output logic [DATA_WIDTH-1:0]    CPU_RDATA,
  output logic                     CPU_RVALID,
  output logic                     RUN,
  output logic [15:0]              LOAD_COUNT,
  output logic [DATA_WIDTH-1:0]    CHECKSUM,
  output logic                     ADDR_ERR
);

  localparam int unsigned IdxWidth = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDRESS_WIDTH:0] DepthLimit = (ADDRESS_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(MEM_DEPTH - 1);

  state_e                  state_q;
  logic [IdxWidth-1:0]     clear_ptr_q;
  logic                    load_ready_q;
  logic                    run_q;
  logic                    rvalid_q;
  logic                    rd_oor_q;
  logic                    addr_err_q;
  logic [15:0]             load_count_q;
  logic [DATA_WIDTH-1:0]   checksum_q;

  logic                    load_in_range;
  logic                    cpu_in_range;
  logic                    ram_we;
  logic [IdxWidth-1:0]     ram_addr;
  logic [DATA_WIDTH-1:0]   ram_wdata;
  logic [DATA_WIDTH-1:0]   ram_rdata;

  assign load_in_range = {1'b0, LOAD_ADDR} < DepthLimit;
  assign cpu_in_range  = {1'b0, CPU_ADDR} < DepthLimit;

  // RAM port owner follows the state; out-of-range writes never reach the array.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = clear_ptr_q;
    ram_wdata = '0;
    unique case (state_q)
      StClear: begin
        ram_we = 1'b1;
      end
      StLoad: begin
        ram_addr  = LOAD_ADDR[IdxWidth-1:0];
        ram_wdata = LOAD_DATA;
        ram_we    = LOAD_VALID && load_in_range;
      end
      StRun: begin
        ram_addr  = CPU_ADDR[IdxWidth-1:0];
        ram_wdata = CPU_WDATA;
        ram_we    = CPU_WR && cpu_in_range;
      end
      default: ;
    endcase
  end

  bat_amateur_ram #(
    .DataWidth (DATA_WIDTH),
    .Depth     (MEM_DEPTH),
    .IdxWidth  (IdxWidth)
  ) u_ram (
    .clk_i   (CLK),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= StClear;
      clear_ptr_q  <= '0;
      load_ready_q <= 1'b0;
      run_q        <= 1'b0;
      rvalid_q     <= 1'b0;
      rd_oor_q     <= 1'b0;
      addr_err_q   <= 1'b0;
      load_count_q <= '0;
      checksum_q   <= '0;
    end else begin
      rvalid_q <= 1'b0;
      rd_oor_q <= 1'b0;
      unique case (state_q)
        StClear: begin
          if (clear_ptr_q == LastIdx) begin
            clear_ptr_q <= '0;
            if (HALT) begin
              state_q      <= StLoad;
              load_ready_q <= 1'b1;
            end else begin
              state_q <= StRun;
              run_q   <= 1'b1;
            end
          end else begin
            clear_ptr_q <= clear_ptr_q + 1'b1;
          end
        end
        StLoad: begin
          if (LOAD_VALID) begin
            if (load_in_range) begin
              if (load_count_q != 16'hFFFF) begin
                load_count_q <= load_count_q + 16'd1;
              end
              checksum_q <= checksum_q + LOAD_DATA;
            end else begin
              addr_err_q <= 1'b1;
            end
          end
          if (!HALT) begin
            state_q      <= StRun;
            load_ready_q <= 1'b0;
            run_q        <= 1'b1;
          end
        end
        StRun: begin
          // A read issued in the halting cycle still completes next cycle.
          if (CPU_RD) begin
            rvalid_q <= 1'b1;
            rd_oor_q <= !cpu_in_range;
          end
          if ((CPU_RD || CPU_WR) && !cpu_in_range) begin
            addr_err_q <= 1'b1;
          end
          if (HALT) begin
            state_q      <= StLoad;
            run_q        <= 1'b0;
            load_ready_q <= 1'b1;
          end
        end
        default: state_q <= StClear;
      endcase
    end
  end

  assign LOAD_READY = load_ready_q;
  assign RUN        = run_q;
  assign CPU_RVALID = rvalid_q;
  assign CPU_RDATA  = (rvalid_q && !rd_oor_q) ? ram_rdata : '0;
  assign LOAD_COUNT = load_count_q;
  assign CHECKSUM   = checksum_q;
  assign ADDR_ERR   = addr_err_q;

endmodule

// File: tb/tb_bat_amateur_boot_mem.sv
// Randomized bench for bat_amateur_boot_mem against an array-based reference model.
module tb_bat_amateur_boot_mem;

  localparam int unsigned Depth = 256;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        HALT;
  logic        LOAD_VALID;
  logic [15:0] LOAD_ADDR;
  logic [15:0] LOAD_DATA;
  logic        LOAD_READY;
  logic        CPU_RD;
  logic        CPU_WR;
  logic [15:0] CPU_ADDR;
  logic [15:0] CPU_WDATA;
  logic [15:0] CPU_RDATA;
  logic        CPU_RVALID;
  logic        RUN;
  logic [15:0] LOAD_COUNT;
  logic [15:0] CHECKSUM;
  logic        ADDR_ERR;

  bat_amateur_boot_mem #(
    .ADDRESS_WIDTH (16),
    .DATA_WIDTH    (16),
    .MEM_DEPTH     (Depth)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .HALT       (HALT),
    .LOAD_VALID (LOAD_VALID),
    .LOAD_ADDR  (LOAD_ADDR),
    .LOAD_DATA  (LOAD_DATA),
    .LOAD_READY (LOAD_READY),
    .CPU_RD     (CPU_RD),
    .CPU_WR     (CPU_WR),
    .CPU_ADDR   (CPU_ADDR),
    .CPU_WDATA  (CPU_WDATA),
    .CPU_RDATA  (CPU_RDATA),
    .CPU_RVALID (CPU_RVALID),
    .RUN        (RUN),
    .LOAD_COUNT (LOAD_COUNT),
    .CHECKSUM   (CHECKSUM),
    .ADDR_ERR   (ADDR_ERR)
  );

  initial forever #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: memory image, counters and sticky error flag.
  logic [15:0] ref_mem [Depth];
  int unsigned ref_count;
  logic [15:0] ref_sum;
  logic        ref_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < Depth; i++) ref_mem[i] = 16'h0000;
    ref_count = 0;
    ref_sum   = 16'h0000;
    ref_err   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_load_ready"}, LOAD_READY, 0);
    check_eq({tag, "_run"}, RUN, 0);
    check_eq({tag, "_rvalid"}, CPU_RVALID, 0);
    check_eq({tag, "_rdata"}, CPU_RDATA, 0);
    check_eq({tag, "_count"}, LOAD_COUNT, 0);
    check_eq({tag, "_checksum"}, CHECKSUM, 0);
    check_eq({tag, "_addr_err"}, ADDR_ERR, 0);
  endtask

  task automatic load_word(input logic [15:0] a, input logic [15:0] d);
    LOAD_VALID = 1'b1;
    LOAD_ADDR  = a;
    LOAD_DATA  = d;
    tick();
    LOAD_VALID = 1'b0;
    if (a < Depth) begin
      ref_mem[a[7:0]] = d;
      if (ref_count < 65535) ref_count++;
      ref_sum = ref_sum + d;
    end else begin
      ref_err = 1'b1;
    end
  endtask

  task automatic cpu_op(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] d);
    logic [15:0] exp_rd;
    exp_rd = (a < Depth) ? ref_mem[a[7:0]] : 16'h0000;
    if (a >= Depth && (rd || wr)) ref_err = 1'b1;
    if (wr && a < Depth) ref_mem[a[7:0]] = d;
    CPU_RD    = rd;
    CPU_WR    = wr;
    CPU_ADDR  = a;
    CPU_WDATA = d;
    tick();
    CPU_RD = 1'b0;
    CPU_WR = 1'b0;
    check_eq("cpu_rvalid", CPU_RVALID, rd);
    if (rd) check_eq("cpu_rdata", CPU_RDATA, exp_rd);
  endtask

  // Counts cycles from reset release until the target flag rises, with CPU reads hammering.
  task automatic wait_rise(input string tag, input bit use_run, input int exp_cycles);
    int n    = 0;
    bit seen = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      CPU_RD   = 1'b1;
      CPU_ADDR = 16'($urandom_range(0, 255));
      tick();
      if (CPU_RVALID) seen = 1'b1;
      if ((use_run ? RUN : LOAD_READY) === 1'b1) begin
        n = i;
        break;
      end
    end
    CPU_RD = 1'b0;
    check_eq({tag, "_cycles"}, n, exp_cycles);
    check_eq({tag, "_no_rvalid"}, seen, 0);
  endtask

  initial begin
    RESET      = 1'b1;
    HALT       = 1'b1;
    LOAD_VALID = 1'b0;
    LOAD_ADDR  = '0;
    LOAD_DATA  = '0;
    CPU_RD     = 1'b0;
    CPU_WR     = 1'b0;
    CPU_ADDR   = '0;
    CPU_WDATA  = '0;
    model_reset();
    tick();
    tick();
    check_all_zero("reset");

    // Clear sweep, then load mode.
    RESET = 1'b0;
    wait_rise("clear_to_load", 1'b0, Depth);
    check_eq("load_run_low", RUN, 0);

    load_word(16'h0010, 16'h0000);
    load_word(16'h0011, 16'h0001);
    load_word(16'h0012, 16'h0005);
    load_word(16'h0000, 16'h0012);
    check_eq("count_4", LOAD_COUNT, 4);
    check_eq("checksum_18", CHECKSUM, 16'h0018);
    check_eq("no_err_yet", ADDR_ERR, 0);

    load_word(16'h0100, 16'hDEAD);
    check_eq("oor_load_err", ADDR_ERR, 1);
    check_eq("oor_load_count", LOAD_COUNT, 4);
    check_eq("oor_load_checksum", CHECKSUM, 16'h0018);

    HALT = 1'b0;
    tick();
    check_eq("run_entry", RUN, 1);
    check_eq("run_entry_ready", LOAD_READY, 0);

    cpu_op(1'b1, 1'b0, 16'h0012, 16'h0000);
    check_eq("rdata_0x12", CPU_RDATA, 16'h0005);
    cpu_op(1'b1, 1'b0, 16'h0100, 16'h0000);
    check_eq("oor_read_zero", CPU_RDATA, 0);

    cpu_op(1'b0, 1'b1, 16'h0005, 16'h73E1);
    cpu_op(1'b1, 1'b1, 16'h0005, 16'hBEEF);
    check_eq("rbw_old", CPU_RDATA, 16'h73E1);
    cpu_op(1'b1, 1'b0, 16'h0005, 16'h0000);
    check_eq("rbw_new", CPU_RDATA, 16'hBEEF);

    for (int i = 0; i < 40; i++) begin
      cpu_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             16'($urandom_range(0, 299)), 16'($urandom));
    end
    check_eq("run_addr_err", ADDR_ERR, ref_err);

    // Halt with a read in flight.
    HALT      = 1'b1;
    CPU_RD    = 1'b1;
    CPU_ADDR  = 16'h0000;
    tick();
    CPU_RD = 1'b0;
    check_eq("halt_rvalid", CPU_RVALID, 1);
    check_eq("halt_rdata", CPU_RDATA, ref_mem[0]);
    check_eq("halt_run", RUN, 0);
    check_eq("halt_ready", LOAD_READY, 1);
    check_eq("halt_count", LOAD_COUNT, ref_count);
    check_eq("halt_checksum", CHECKSUM, ref_sum);
    tick();
    check_eq("halt_rvalid_once", CPU_RVALID, 0);

    for (int i = 0; i < 12; i++) begin
      load_word(16'($urandom_range(0, 270)), 16'($urandom));
    end
    check_eq("reload_count", LOAD_COUNT, ref_count);
    check_eq("reload_checksum", CHECKSUM, ref_sum);
    check_eq("reload_err", ADDR_ERR, ref_err);

    // Asynchronous reset in the middle of a load burst.
    load_word(16'h0010, 16'h1111);
    load_word(16'h0011, 16'h2222);
    load_word(16'h0012, 16'h3333);
    RESET = 1'b1;
    #2;
    check_all_zero("async_reset");
    model_reset();
    tick();
    HALT  = 1'b0;
    RESET = 1'b0;
    wait_rise("clear_to_run", 1'b1, Depth);
    check_eq("rerun_ready_low", LOAD_READY, 0);
    cpu_op(1'b1, 1'b0, 16'h0010, 16'h0000);
    cpu_op(1'b1, 1'b0, 16'h0012, 16'h0000);
    cpu_op(1'b1, 1'b0, 16'h0005, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      cpu_op(1'b1, 1'b0, 16'($urandom_range(0, 255)), 16'h0000);
    end
    check_eq("rerun_count", LOAD_COUNT, 0);
    check_eq("rerun_err", ADDR_ERR, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
